// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receiving end of a 4-slot time-division serial link.
//
// Aligns to a frame-sync strobe, steps an internal slot counter, collects each
// slot's bit in a shadow register and presents all four channels together as a
// registered parallel word with a one-cycle valid pulse.
//
// Optional feature macro: TDM_DEMUX_PARITY_EN
//   defined   : 5-slot frame, slot 4 carries even parity over a..d,
//               parity_err pulses alongside frame_valid on a mismatch.
//   undefined : 4-slot frame, parity_err tied to 0.
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst         in   1  synchronous active-high reset
//   din         in   1  serial data, one slot bit per clock
//   sync        in   1  frame strobe, high with the slot-0 bit
//   a, b, c, d  out  1  channels 0..3, registered, hold between frames
//   slot        out  3  slot index the next din sample belongs to
//   frame_valid out  1  one-cycle pulse, a..d updated this cycle
//   frame_err   out  1  one-cycle pulse, sync arrived mid-frame
//   parity_err  out  1  one-cycle pulse with frame_valid on parity mismatch

module tdm_demux4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       sync,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [2:0] slot,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam logic [2:0] LastSlot = 3'd4;
    localparam int unsigned ShadowW = 4;  // slot 3 also needs a shadow bit
`else
    localparam logic [2:0] LastSlot = 3'd3;
    localparam int unsigned ShadowW = 3;  // slot 3 loads straight from din
`endif

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           slot_q, slot_d;
    logic [ShadowW-1:0]   shadow_q, shadow_d;
    logic [3:0]           chan_q, chan_d;  // {a, b, c, d}
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic                 perr_q, perr_d;
`endif

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        chan_d   = chan_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        perr_d   = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (sync) begin
                    shadow_d[0] = din;
                    slot_d      = 3'd1;
                    state_d     = StRun;
                end
            end

            StRun: begin
                if (sync) begin
                    // Realign; a sync anywhere but slot 0 drops the partial frame.
                    ferr_d      = (slot_q != 3'd0);
                    shadow_d[0] = din;
                    slot_d      = 3'd1;
                end else if (slot_q == LastSlot) begin
`ifdef TDM_DEMUX_PARITY_EN
                    chan_d = {shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3]};
                    // Even parity: a^b^c^d^p must be 0.
                    perr_d = (^shadow_q) ^ din;
`else
                    chan_d = {shadow_q[0], shadow_q[1], shadow_q[2], din};
`endif
                    valid_d = 1'b1;
                    slot_d  = 3'd0;
                end else begin
                    case (slot_q)
                        3'd0:    shadow_d[0] = din;
                        3'd1:    shadow_d[1] = din;
                        3'd2:    shadow_d[2] = din;
`ifdef TDM_DEMUX_PARITY_EN
                        3'd3:    shadow_d[3] = din;
`endif
                        default: ;
                    endcase
                    slot_d = slot_q + 3'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State registers; reset wins over sync in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            slot_q   <= 3'd0;
            shadow_q <= '0;
            chan_q   <= 4'd0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
`ifdef TDM_DEMUX_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    assign a           = chan_q[3];
    assign b           = chan_q[2];
    assign c           = chan_q[1];
    assign d           = chan_q[0];
    assign slot        = slot_q;
    assign frame_valid = valid_q;
    assign frame_err   = ferr_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int FL  = 5;
    localparam bit Par = 1'b1;
`else
    localparam int FL  = 4;
    localparam bit Par = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       sync = 1'b0;
    logic       a, b, c, d;
    logic [2:0] slot;
    logic       frame_valid, frame_err, parity_err;

    int errors = 0;
    int checks = 0;
    logic [3:0] prev_outs = 4'b0000;

    tdm_demux4 dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .sync        (sync),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .slot        (slot),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs for one edge, then sample 1 time unit after it.
    task automatic tick(input logic s, input logic dv);
        sync = s;
        din  = dv;
        @(posedge clk);
        #1;
    endtask

    // One full frame; bits = {a,b,c,d}, a sent first.
    task automatic send_frame(input logic s, input logic [3:0] bits, input logic good_par,
                              input logic exp_fe);
        for (int i = 0; i < FL; i++) begin
            logic       bitv;
            logic [1:0] idx;
            if (i < 4) begin
                idx  = 2'(3 - i);
                bitv = bits[idx];
            end else begin
                bitv = good_par ? (^bits) : ~(^bits);
            end
            tick((i == 0) ? s : 1'b0, bitv);
            if (i == FL - 1) begin
                check("done_valid", {7'd0, frame_valid}, 8'd1);
                check("done_outs", {4'd0, a, b, c, d}, {4'd0, bits});
                check("done_slot", {5'd0, slot}, 8'd0);
                check("done_ferr", {7'd0, frame_err}, 8'd0);
                check("done_perr", {7'd0, parity_err}, {7'd0, Par & ~good_par});
            end else begin
                check("mid_valid", {7'd0, frame_valid}, 8'd0);
                check("mid_hold", {4'd0, a, b, c, d}, {4'd0, prev_outs});
                check("mid_slot", {5'd0, slot}, 8'(i + 1));
                check("mid_ferr", {7'd0, frame_err}, (i == 0) ? {7'd0, exp_fe} : 8'd0);
            end
        end
        prev_outs = bits;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        check("rst_outs", {4'd0, a, b, c, d}, 8'd0);
        check("rst_slot", {5'd0, slot}, 8'd0);
        check("rst_flags", {5'd0, frame_valid, frame_err, parity_err}, 8'd0);
        rst = 1'b0;

        // Idle: din ignored without sync
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'(i));
            check("idle_outs", {4'd0, a, b, c, d}, 8'd0);
            check("idle_valid", {7'd0, frame_valid}, 8'd0);
            check("idle_slot", {5'd0, slot}, 8'd0);
        end

        // First aligned frame, then free-running frame without sync
        send_frame(1'b1, 4'b1011, 1'b1, 1'b0);
        send_frame(1'b0, 4'b0100, 1'b1, 1'b0);

        // Walking one plus all-zero, back to back
        send_frame(1'b0, 4'b1000, 1'b1, 1'b0);
        send_frame(1'b0, 4'b0100, 1'b1, 1'b0);
        send_frame(1'b0, 4'b0010, 1'b1, 1'b0);
        send_frame(1'b0, 4'b0001, 1'b1, 1'b0);
        send_frame(1'b0, 4'b0000, 1'b1, 1'b0);

        // Sync at slot 0 in RUN is a clean realignment
        send_frame(1'b1, 4'b1111, 1'b1, 1'b0);

        // Sync at slot 2: partial frame dropped, frame_err on next cycle
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("pre_err_slot", {5'd0, slot}, 8'd2);
        send_frame(1'b1, 4'b0110, 1'b1, 1'b1);

        // Reset at slot 2 with sync high: reset wins
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        check("pre_rst_slot", {5'd0, slot}, 8'd2);
        rst = 1'b1;
        tick(1'b1, 1'b1);
        check("midrst_outs", {4'd0, a, b, c, d}, 8'd0);
        check("midrst_slot", {5'd0, slot}, 8'd0);
        check("midrst_flags", {5'd0, frame_valid, frame_err, parity_err}, 8'd0);
        rst = 1'b0;
        prev_outs = 4'b0000;
        for (int i = 0; i < FL + 2; i++) begin
            tick(1'b0, 1'b1);
            check("post_rst_slot", {5'd0, slot}, 8'd0);
            check("post_rst_valid", {7'd0, frame_valid}, 8'd0);
        end
        send_frame(1'b1, 4'b1001, 1'b1, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
        // Good parity then bad parity on 1101
        send_frame(1'b0, 4'b1101, 1'b1, 1'b0);
        send_frame(1'b0, 4'b1101, 1'b0, 1'b0);
`endif

        // Pulses are single-cycle
        tick(1'b0, 1'b0);
        check("end_valid_low", {7'd0, frame_valid}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
